seq_magnitude_comparator: RTL and testbench



---
 rtl/comparator_pkg.sv | 39 +++
 rtl/slice_cmp.sv | 34 +++
 rtl/seq_magnitude_comparator.sv | 133 +++++++++++++
 tb/tb_seq_magnitude_comparator.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/comparator_pkg.sv
// Shared types and constants for the sequential magnitude comparator.
// Holds the two-state FSM encoding, the packed {lt, gt, eq} result type
// and the constant result codes used by the top level and slice_cmp.
package comparator_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } state_t;

    typedef struct packed {
        logic lt;
        logic gt;
        logic eq;
    } cmp_res_t;

    localparam cmp_res_t RES_EQ   = 3'b001;
    localparam cmp_res_t RES_GT   = 3'b010;
    localparam cmp_res_t RES_LT   = 3'b100;
    localparam cmp_res_t RES_NONE = 3'b000;

    // Resolves a fully equal compare using the lower-order cascade inputs.
    // cas_eq wins; otherwise lt/gt pass straight through, even when both
    // are set or both clear.
    function automatic cmp_res_t cascade_result(input logic cas_lt,
                                                input logic cas_gt,
                                                input logic cas_eq);
        cmp_res_t r;
        if (cas_eq) begin
            r = RES_EQ;
        end else begin
            r.lt = cas_lt;
            r.gt = cas_gt;
            r.eq = 1'b0;
        end
        return r;
    endfunction

endpackage

// File: rtl/slice_cmp.sv
// Combinational compare of one SLICE-bit slice of the two operands.
// When signed_top is set the slice is the most significant one of a
// two's complement operand, so its MSB is inverted on both sides, which
// turns an unsigned compare into a signed one for that slice only.
module slice_cmp
    import comparator_pkg::*;
#(
    parameter int SLICE = 4
) (
    input  logic [SLICE-1:0] a,
    input  logic [SLICE-1:0] b,
    input  logic             signed_top,
    output cmp_res_t         res,
    output logic             equal
);

    logic [SLICE-1:0] a_adj;
    logic [SLICE-1:0] b_adj;

    // Apply the optional sign flip, then do a plain unsigned compare.
    always_comb begin
        a_adj = a;
        b_adj = b;
        if (signed_top) begin
            a_adj[SLICE-1] = ~a[SLICE-1];
            b_adj[SLICE-1] = ~b[SLICE-1];
        end
        res.lt = (a_adj < b_adj);
        res.gt = (a_adj > b_adj);
        res.eq = (a_adj == b_adj);
        equal  = (a_adj == b_adj);
    end

endmodule

// File: rtl/seq_magnitude_comparator.sv
// Multi-cycle magnitude comparator for wide operands.
// Operands are captured on start and scanned MSB-first one SLICE-bit slice
// per clock; the scan stops at the first differing slice, and a fully
// equal compare is resolved from the cascade inputs.
// Optional feature: define COMPARATOR_SIGNED_EN to treat the operands as
// two's complement (only the top slice is compared signed).
module seq_magnitude_comparator
    import comparator_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int SLICE = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cas_lt,
    input  logic             cas_gt,
    input  logic             cas_eq,
    output logic             busy,
    output logic             done,
    output logic             lt,
    output logic             gt,
    output logic             eq
);

    localparam int NSLICE = WIDTH / SLICE;
    localparam int IDX_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(NSLICE - 1);

    if ((WIDTH % SLICE) != 0 || SLICE < 1) begin : g_bad_width
        $error("seq_magnitude_comparator: WIDTH must be a multiple of SLICE");
    end

    state_t           state;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic             cas_lt_q;
    logic             cas_gt_q;
    logic             cas_eq_q;
    logic [IDX_W-1:0] idx;
    cmp_res_t         res_q;
    logic             done_q;

    logic [SLICE-1:0] a_slice;
    logic [SLICE-1:0] b_slice;
    logic             signed_top;
    cmp_res_t         slice_res;
    logic             slice_equal;

    // Select the slice currently being examined out of the captured operands.
    always_comb begin
        a_slice = '0;
        b_slice = '0;
        for (int i = 0; i < NSLICE; i++) begin
            if (idx == IDX_W'(i)) begin
                a_slice = a_q[i*SLICE +: SLICE];
                b_slice = b_q[i*SLICE +: SLICE];
            end
        end
    end

`ifdef COMPARATOR_SIGNED_EN
    assign signed_top = (idx == IDX_TOP);
`else
    assign signed_top = 1'b0;
`endif

    slice_cmp #(
        .SLICE (SLICE)
    ) u_slice_cmp (
        .a          (a_slice),
        .b          (b_slice),
        .signed_top (signed_top),
        .res        (slice_res),
        .equal      (slice_equal)
    );

    // Capture on start, walk the slices down, and publish the result with a
    // one-cycle done pulse; results are held between compares.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            cas_lt_q <= 1'b0;
            cas_gt_q <= 1'b0;
            cas_eq_q <= 1'b0;
            idx      <= IDX_TOP;
            res_q    <= RES_NONE;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        a_q      <= a;
                        b_q      <= b;
                        cas_lt_q <= cas_lt;
                        cas_gt_q <= cas_gt;
                        cas_eq_q <= cas_eq;
                        idx      <= IDX_TOP;
                        state    <= SCAN;
                    end
                end
                SCAN: begin
                    if (!slice_equal) begin
                        res_q  <= slice_res;
                        done_q <= 1'b1;
                        state  <= IDLE;
                    end else if (idx != '0) begin
                        idx <= idx - 1'b1;
                    end else begin
                        res_q  <= cascade_result(cas_lt_q, cas_gt_q, cas_eq_q);
                        done_q <= 1'b1;
                        state  <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign busy = (state == SCAN);
    assign done = done_q;
    assign lt   = res_q.lt;
    assign gt   = res_q.gt;
    assign eq   = res_q.eq;

endmodule

// File: tb/tb_seq_magnitude_comparator.sv
// Self-checking bench for seq_magnitude_comparator (WIDTH=16, SLICE=4).
// Expected results and latencies come from a whole-number reference model;
// honours COMPARATOR_SIGNED_EN when the build defines it.
module tb_seq_magnitude_comparator;

    localparam int WIDTH  = 16;
    localparam int SLICE  = 4;
    localparam int NSLICE = WIDTH / SLICE;
    localparam int MAX_WAIT = 20;

    logic             clk;
    logic             rst;
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cas_lt;
    logic             cas_gt;
    logic             cas_eq;
    logic             busy;
    logic             done;
    logic             lt;
    logic             gt;
    logic             eq;

    int checks;
    int errors;

    seq_magnitude_comparator #(
        .WIDTH (WIDTH),
        .SLICE (SLICE)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .a      (a),
        .b      (b),
        .cas_lt (cas_lt),
        .cas_gt (cas_gt),
        .cas_eq (cas_eq),
        .busy   (busy),
        .done   (done),
        .lt     (lt),
        .gt     (gt),
        .eq     (eq)
    );

    // Free-running clock.
    always #5 clk = ~clk;

    // Reference result {lt, gt, eq} computed on the whole operands.
    function automatic logic [2:0] modelResult(input logic [WIDTH-1:0] ma,
                                               input logic [WIDTH-1:0] mb,
                                               input logic ml,
                                               input logic mg,
                                               input logic me);
        logic is_lt;
        logic is_gt;
`ifdef COMPARATOR_SIGNED_EN
        is_lt = ($signed(ma) < $signed(mb));
        is_gt = ($signed(ma) > $signed(mb));
`else
        is_lt = (ma < mb);
        is_gt = (ma > mb);
`endif
        if (is_lt) return 3'b100;
        if (is_gt) return 3'b010;
        if (me)    return 3'b001;
        return {ml, mg, 1'b0};
    endfunction

    // Reference latency: number of slices examined, MSB-first, until the
    // first slice that differs (all of them when the operands are equal).
    function automatic int modelLatency(input logic [WIDTH-1:0] ma,
                                        input logic [WIDTH-1:0] mb);
        logic [WIDTH-1:0] diff;
        diff = ma ^ mb;
        for (int s = NSLICE - 1; s >= 0; s--) begin
            if (((diff >> (s * SLICE)) & ((1 << SLICE) - 1)) != 0)
                return NSLICE - s;
        end
        return NSLICE;
    endfunction

    task automatic checkOutput(input string tag, input int observed, input int expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    // Called at a negedge: presents operands with start high, lets the next
    // rising edge accept them, and returns at the following negedge.
    task automatic applyStimulus(input logic [WIDTH-1:0] ia, input logic [WIDTH-1:0] ib,
                                 input logic il, input logic ig, input logic ie);
        a      = ia;
        b      = ib;
        cas_lt = il;
        cas_gt = ig;
        cas_eq = ie;
        start  = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checkOutput("busy_after_accept", int'(busy), 1);
        checkOutput("done_low_after_accept", int'(done), 0);
    endtask

    // Counts cycles from the acceptance negedge until done, bounded.
    task automatic waitDone(output int cycles);
        cycles = 0;
        while (!done && cycles < MAX_WAIT) begin
            @(negedge clk);
            cycles++;
        end
    endtask

    // Full compare: stimulus, wait, then latency/result/busy checks.
    task automatic runCompare(input string tag, input logic [WIDTH-1:0] ia, input logic [WIDTH-1:0] ib,
                              input logic il, input logic ig, input logic ie);
        int cycles;
        applyStimulus(ia, ib, il, ig, ie);
        waitDone(cycles);
        checkOutput({tag, "_latency"}, cycles, modelLatency(ia, ib));
        checkOutput({tag, "_result"}, int'({lt, gt, eq}), int'(modelResult(ia, ib, il, ig, ie)));
        checkOutput({tag, "_busy_at_done"}, int'(busy), 0);
    endtask

    initial begin
        int cycles;
        int saw_done;
        logic [WIDTH-1:0] ra;
        logic [WIDTH-1:0] rb;
        logic [2:0] held;
        logic [2:0] rc;

        checks   = 0;
        errors   = 0;
        clk      = 1'b0;
        rst      = 1'b1;
        start    = 1'b0;
        a        = '0;
        b        = '0;
        cas_lt   = 1'b0;
        cas_gt   = 1'b0;
        cas_eq   = 1'b0;

        // Reset state.
        repeat (2) @(negedge clk);
        checkOutput("reset_outputs", int'({busy, done, lt, gt, eq}), 0);
        rst = 1'b0;
        @(negedge clk);

        // Top slice differs: one-cycle latency.
        runCompare("top_diff", 16'h1234, 16'h0234, 1'b0, 1'b0, 1'b0);
        held = {lt, gt, eq};
        @(negedge clk);
        checkOutput("done_one_cycle", int'(done), 0);
        checkOutput("result_held", int'({lt, gt, eq}), int'(held));

        // Bottom slice differs: full-length scan.
        runCompare("low_diff", 16'h1230, 16'h1234, 1'b0, 1'b0, 1'b0);
        @(negedge clk);

        // Equal operands resolved through the cascade inputs.
        runCompare("cas_eq", 16'h6666, 16'h6666, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        runCompare("cas_lt", 16'h6666, 16'h6666, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        runCompare("cas_both", 16'h6666, 16'h6666, 1'b1, 1'b1, 1'b0);
        @(negedge clk);

        // Start during SCAN is ignored, inputs changing during SCAN too.
        applyStimulus(16'h0001, 16'h0002, 1'b0, 1'b0, 1'b0);
        a     = 16'hFFFF;
        b     = 16'h0000;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        waitDone(cycles);
        checkOutput("ignored_start_latency", cycles, modelLatency(16'h0001, 16'h0002) - 1);
        checkOutput("ignored_start_result", int'({lt, gt, eq}),
                    int'(modelResult(16'h0001, 16'h0002, 1'b0, 1'b0, 1'b0)));

        // Back-to-back: new start issued in the done cycle.
        runCompare("back_to_back", 16'h5000, 16'h4FFF, 1'b0, 1'b0, 1'b0);
        @(negedge clk);

        // Reset two cycles into a compare aborts it with no done.
        applyStimulus(16'h1230, 16'h1234, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        checkOutput("async_reset_outputs", int'({busy, done, lt, gt, eq}), 0);
        @(negedge clk);
        rst = 1'b0;
        saw_done = 0;
        repeat (6) begin
            @(negedge clk);
            if (done) saw_done = 1;
        end
        checkOutput("no_done_after_abort", saw_done, 0);
        runCompare("after_reset", 16'h00A0, 16'h00B0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);

        // Sign-sensitive boundary.
        runCompare("sign_boundary", 16'h8000, 16'h0001, 1'b0, 1'b0, 1'b0);
        @(negedge clk);

        // Randomized compares, some sharing upper slices or fully equal.
        for (int n = 0; n < 24; n++) begin
            ra = 16'($urandom);
            case ($urandom_range(0, 3))
                0:       rb = 16'($urandom);
                1:       rb = ra ^ (16'($urandom_range(1, 15)) << (SLICE * $urandom_range(0, NSLICE - 1)));
                2:       rb = ra;
                default: rb = ra ^ 16'($urandom_range(1, 15));
            endcase
            rc = 3'($urandom);
            runCompare("random", ra, rb, rc[2], rc[1], rc[0]);
            if ($urandom_range(0, 1) == 1) @(negedge clk);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
